// File: rtl/lsh_pkg.sv
// ---------------------------------------------------------------------------
// lsh_pkg
// Shared types and constants for the locality-sensitive hashing front end.
//    base_t           : one 2-bit nucleotide code
//    BASE_A..BASE_T   : nucleotide encodings (A=00, C=01, G=10, T=11)
//    loader_state_t   : window_loader FSM states
//    DEFAULT_*        : default sizing shared by the loader and the hasher
// ---------------------------------------------------------------------------
package lsh_pkg;

   typedef logic [1:0] base_t;

   localparam base_t BASE_A = 2'b00;
   localparam base_t BASE_C = 2'b01;
   localparam base_t BASE_G = 2'b10;
   localparam base_t BASE_T = 2'b11;

   // FILL_INIT   : collecting the first full window of a sequence
   // FILL_STRIDE : collecting the STRIDE new bases for the next window
   // HASH        : window frozen and offered to the hasher
   // END         : single-cycle end-of-sequence marker and cleanup
   typedef enum logic [1:0] {
      FILL_INIT   = 2'd0,
      FILL_STRIDE = 2'd1,
      HASH        = 2'd2,
      END         = 2'd3
   } loader_state_t;

   // Window length must agree with window_hasher
   localparam int DEFAULT_WINDOW_SIZE = 128;
   localparam int DEFAULT_STRIDE      = 64;
   localparam int DEFAULT_CNT_W       = 16;

endpackage

// File: rtl/window_loader.sv
// ---------------------------------------------------------------------------
// window_loader
// Upstream feeder for window_hasher. Accepts a valid/ready stream of 2-bit
// nucleotide codes, assembles them into a WINDOW_SIZE-base sliding window
// that advances by STRIDE bases, freezes each complete window while the
// hasher works on it and flags the end of every sequence.
//
// Ports:
//    clk               : clock
//    reset             : asynchronous, active-high reset
//    base_in_valid     : base_in carries a base this cycle
//    base_in           : nucleotide code
//    base_in_last      : base_in is the final base of its sequence
//    base_in_ready     : loader accepts base_in this cycle
//    window            : current window, index 0 oldest, WINDOW_SIZE-1 newest
//    ready_for_hashing : window is complete and stable
//    hashing_is_done   : one-cycle pulse from the hasher
//    window_count      : windows hashed so far in the current sequence
//    seq_done          : one-cycle pulse at the end of a sequence
//    seq_short         : with seq_done, the sequence produced no window
// ---------------------------------------------------------------------------
module window_loader
   import lsh_pkg::*;
#(
   parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
   parameter int STRIDE      = DEFAULT_STRIDE,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             base_in_valid,
   input  logic [1:0]       base_in,
   input  logic             base_in_last,
   output logic             base_in_ready,
   output logic [1:0]       window [0:WINDOW_SIZE-1],
   output logic             ready_for_hashing,
   input  logic             hashing_is_done,
   output logic [CNT_W-1:0] window_count,
   output logic             seq_done,
   output logic             seq_short
);

   // Fill counter must be able to hold WINDOW_SIZE itself
   localparam int FILL_W = $clog2(WINDOW_SIZE + 1);

   // A stride outside 1..WINDOW_SIZE would either never advance or skip
   // bases between windows, so refuse to elaborate
   generate
      if (STRIDE < 1 || STRIDE > WINDOW_SIZE) begin : g_badStride
         $error("window_loader: STRIDE must lie in 1..WINDOW_SIZE");
      end
   endgenerate

   loader_state_t     r_state;
   loader_state_t     w_nextState;
   logic [FILL_W-1:0] r_fillCnt;
   logic [FILL_W-1:0] w_fillTarget;
   base_t             r_window [0:WINDOW_SIZE-1];
   logic [CNT_W-1:0]  r_windowCount;
   logic              r_lastPending;
   logic              r_readyForHashing;
   logic              w_accepting;
   logic              w_transfer;
   logic              w_fillComplete;
   logic              w_hashDone;

   // Handshake and window-completion decode. The first window of a sequence
   // needs a full WINDOW_SIZE bases; every later one only STRIDE new bases
   // because the older part of the window is reused.
   always_comb begin
      w_accepting    = !reset && ((r_state == FILL_INIT) || (r_state == FILL_STRIDE));
      w_transfer     = base_in_valid && w_accepting;
      w_fillTarget   = (r_state == FILL_INIT) ? FILL_W'(WINDOW_SIZE) : FILL_W'(STRIDE);
      w_fillComplete = w_transfer && ((r_fillCnt + FILL_W'(1)) == w_fillTarget);
      w_hashDone     = (r_state == HASH) && hashing_is_done;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FILL_INIT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. A last base that completes a window still gets that
   // window hashed first; the END visit happens once the hasher is done.
   // A last base that does not complete a window drops the partial bases and
   // goes straight to END. Done pulses outside HASH are ignored because the
   // hasher's done may linger after it has been consumed.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         FILL_INIT, FILL_STRIDE: begin
            if (w_fillComplete) begin
               w_nextState = HASH;
            end else if (w_transfer && base_in_last) begin
               w_nextState = END;
            end
         end
         HASH: begin
            if (hashing_is_done) begin
               w_nextState = r_lastPending ? END : FILL_STRIDE;
            end
         end
         END: begin
            w_nextState = FILL_INIT;
         end
         default: begin
            w_nextState = FILL_INIT;
         end
      endcase
   end

   // Outputs. ready_for_hashing comes straight from a flop so the hasher
   // sees a clean level; the END markers are decodes of the state register.
   always_comb begin
      base_in_ready     = w_accepting;
      ready_for_hashing = r_readyForHashing;
      seq_done          = (r_state == END);
      seq_short         = (r_state == END) && (r_windowCount == '0);
      window_count      = r_windowCount;
      window            = r_window;
   end

   // ready_for_hashing tracks whether the FSM will sit in HASH next cycle,
   // which gives the one-cycle delay after the completing transfer and
   // drops it the cycle after the done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readyForHashing <= 1'b0;
      end else begin
         r_readyForHashing <= (w_nextState == HASH);
      end
   end

   // Sliding window shift register. Bases only enter while filling, so the
   // window is naturally frozen in HASH. END wipes it so the next sequence
   // never sees stale bases.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            r_window[i] <= BASE_A;
         end
      end else if (r_state == END) begin
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            r_window[i] <= BASE_A;
         end
      end else if (w_transfer) begin
         for (int i = 0; i < WINDOW_SIZE - 1; i++) begin
            r_window[i] <= r_window[i+1];
         end
         r_window[WINDOW_SIZE-1] <= base_in;
      end
   end

   // Fill counter restarts on every completed window so it always counts
   // toward the target of the fill phase currently in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fillCnt <= '0;
      end else if (r_state == END) begin
         r_fillCnt <= '0;
      end else if (w_fillComplete) begin
         r_fillCnt <= '0;
      end else if (w_transfer) begin
         r_fillCnt <= r_fillCnt + FILL_W'(1);
      end
   end

   // Remember whether the base that completed the current window was the
   // last of its sequence, so END follows this window's hash
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lastPending <= 1'b0;
      end else if (r_state == END) begin
         r_lastPending <= 1'b0;
      end else if (w_fillComplete) begin
         r_lastPending <= base_in_last;
      end
   end

   // Per-sequence window counter; it saturates rather than wrapping so a
   // very long sequence never reports a misleadingly small count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_windowCount <= '0;
      end else if (r_state == END) begin
         r_windowCount <= '0;
      end else if (w_hashDone && (r_windowCount != '1)) begin
         r_windowCount <= r_windowCount + CNT_W'(1);
      end
   end

endmodule
